// File: rtl/apb_slave_regfile.sv
// APB completer fronting a DEPTH x 8-bit register file. Each access takes
// WAIT_CYCLES extra access-phase cycles and then one registered pready pulse.
module apb_slave_regfile #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       prst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr
);

  localparam int         DATA_W   = 8;
  localparam int         ADDR_W   = 8;
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  // Code 2'd3 is unused and handled by the default branch as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [IDX_W-1:0]    idx;

  // Unsigned 8-bit range check; the extra bit lets DEPTH=256 compare correctly.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < 9'(DEPTH));
  endfunction

  assign idx = addr_q[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_d     = mem_q;
    case (state_q)
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d  = ST_RESP;
            pready_d = 1'b1;
            if (!addr_ok(addr_q)) begin
              pslverr_d = 1'b1;
            end else if (write_q) begin
              mem_d[idx] = wdata_q;
            end else begin
              prdata_d = mem_q[idx];
            end
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Only a true setup phase starts a transfer; psel with penable is ignored.
        if (psel && !penable) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          write_d = pwrite;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      mem_q     <= mem_d;
    end
  end

  // Setup-phase address/data latch is only consumed after a fresh setup.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile: two instances (W=2 and W=0) checked
// against an array model of the register file and the pready timing rule.
module tb_apb_slave_regfile;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       prst = 1'b1;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  int         wc [2] = '{2, 0};
  logic [7:0] model [2][256];
  int         errs   = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .prst(prst), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_slave_regfile #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .prst(prst), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 256; a++)
        model[u][a] = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        psel[u] = 1'b0;
        penable[u] = 1'b0;
      end
    end
  endtask

  // One transfer starting at the next clock; returns at the negedge of the
  // pready cycle so a following call forms a back-to-back transfer.
  task automatic xfer(input int u, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input int hold, input bit perturb, input logic [7:0] pa,
                      input logic [7:0] pd, input bit rst_resp);
    logic [7:0] exp_rd;
    bit         exp_err;
    exp_err = (a >= 8'(DEPTH));
    exp_rd  = (!wr && !exp_err) ? model[u][a] : 8'h00;
    @(posedge clk); #1;
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = wr; paddr[u] = a; pwdata[u] = d;
    @(negedge clk);
    check("pready_setup", pready[u], 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("pready_hold", pready[u], 0);
    end
    for (int k = 1; k <= wc[u] + 2; k++) begin
      @(posedge clk); #1;
      penable[u] = 1'b1;
      if (perturb) begin
        paddr[u] = pa;
        pwdata[u] = pd;
      end
      @(negedge clk);
      check("pready_cycle", pready[u], (k == wc[u] + 2) ? 1 : 0);
      if (k < wc[u] + 2) check("pslverr_idle", pslverr[u], 0);
    end
    check("prdata", prdata[u], exp_rd);
    check("pslverr", pslverr[u], exp_err);
    if (wr && !exp_err) model[u][a] = d;
    if (rst_resp) begin
      #1 prst = 1'b1;
      #1;
      check("rst_pready", pready[u], 0);
      check("rst_pslverr", pslverr[u], 0);
      check("rst_prdata", prdata[u], 0);
      psel[u] = 1'b0; penable[u] = 1'b0;
      clear_model();
      @(posedge clk); #1;
      @(posedge clk); #1;
      prst = 1'b0;
    end
  endtask

  task automatic rd(input int u, input logic [7:0] a);
    xfer(u, 1'b0, a, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic wr(input int u, input logic [7:0] a, input logic [7:0] d);
    xfer(u, 1'b1, a, d, 0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic abort_xfer(input int u, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    psel[u] = 1'b1; penable[u] = 1'b0; pwrite[u] = 1'b1; paddr[u] = a; pwdata[u] = d;
    @(posedge clk); #1;
    psel[u] = 1'b0; penable[u] = 1'b0;
    for (int k = 0; k < wc[u] + 3; k++) begin
      @(negedge clk);
      check("pready_abort", pready[u], 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic violation(input int u);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      psel[u] = 1'b1; penable[u] = 1'b1; pwrite[u] = 1'b1;
      paddr[u] = 8'h01; pwdata[u] = 8'hEE;
      @(negedge clk);
      check("pready_violation", pready[u], 0);
    end
    idle(1);
  endtask

  initial begin
    int u, last_u, op;
    logic [7:0] ra, rdt;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
      paddr[i] = 8'h00; pwdata[i] = 8'h00;
    end
    clear_model();
    repeat (3) @(posedge clk);
    #1 prst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_pready", pready[i], 0);
      check("reset_pslverr", pslverr[i], 0);
      check("reset_prdata", prdata[i], 0);
    end

    wr(0, 8'h03, 8'hA5);
    rd(0, 8'h03);
    idle(1);
    wr(0, 8'h10, 8'h77);
    rd(0, 8'h10);
    rd(0, 8'h00);
    idle(1);

    wr(1, 8'h0F, 8'h11);
    rd(1, 8'h0F);
    idle(1);

    abort_xfer(0, 8'h02, 8'h3C);
    rd(0, 8'h02);
    idle(1);

    xfer(0, 1'b1, 8'h04, 8'h5A, 0, 1'b1, 8'h09, 8'hFF, 1'b0);
    rd(0, 8'h04);
    rd(0, 8'h09);
    idle(1);

    xfer(0, 1'b1, 8'h07, 8'h3E, 2, 1'b0, 8'h00, 8'h00, 1'b0);
    xfer(1, 1'b1, 8'h08, 8'h81, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);
    xfer(1, 1'b0, 8'h08, 8'h00, 3, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);
    violation(0);
    rd(0, 8'h01);
    rd(0, 8'h07);
    idle(1);

    last_u = 0;
    for (int n = 0; n < 80; n++) begin
      u  = $urandom_range(0, 1);
      op = $urandom_range(0, 9);
      if (u != last_u) idle(1);
      ra  = 8'($urandom_range(0, 19));
      rdt = 8'($urandom);
      if (op == 0) begin
        abort_xfer(u, ra, rdt);
      end else if (op == 1) begin
        violation(u);
      end else begin
        xfer(u, 1'($urandom), ra, rdt, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
             1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
      end
      last_u = u;
    end
    idle(1);

    wr(0, 8'h05, 8'hC3);
    xfer(0, 1'b0, 8'h05, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b1);
    rd(0, 8'h05);
    idle(1);
    rd(1, 8'h0F);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer (slave) that terminates the bus driven by the team's APB requester block. It services single read/write transfers into a small register file and inserts a programmable number of wait states through `pready`. It flags out-of-range addresses with `pslverr`. It sits directly downstream of the requester, consuming `psel`, `penable`, `pwrite`, `paddr` and `pwdata`, and returning `prdata`, `pready` and `pslverr`.

## Interface
- `DEPTH`, 16: number of 8-bit registers; valid addresses are 0..DEPTH-1, with DEPTH ≤ 256.
- `WAIT_CYCLES`, 2: extra access-phase cycles before `pready`; range 0..15.
- `clk`  in  1  bus clock, the APB clock shared with the requester; all logic on rising edge.
- `prst`  in  1  reset, asynchronous, active-high.
- `psel`  in  1  slave select.
- `penable`  in  1  access-phase indicator.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  8  register address.
- `pwdata`  in  8  write data.
- `prdata`  out  8  read data; valid only while `pready`=1 on a read.
- `pready`  out  1  transfer-complete strobe; registered.
- `pslverr`  out  1  error response; valid only while `pready`=1.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. It is encoded in 2 bits, and code 3 decodes to IDLE.
- **IDLE**
  - On `psel`=1 and `penable`=0 (setup phase), latch `paddr`, `pwrite` and `pwdata`.
  - Load `cnt` ← WAIT_CYCLES and go to WAIT.
  - All other input combinations stay in IDLE.
- **WAIT**
  - If `psel`=0, the transfer is aborted: go to IDLE, with no register update and no response.
  - Else if `penable`=1 and `cnt`≠0, decrement `cnt`.
  - Else if `penable`=1 and `cnt`=0, go to RESP, set `pready`←1 and perform the access.
  - If `penable`=0, hold the state.
- **Access, performed on the edge that enters RESP**
  - If the latched address ≥ DEPTH: `pslverr`←1, `prdata`←0, no write.
  - Valid write: `mem[addr]` ← latched `pwdata`; `prdata`←0; `pslverr`←0.
  - Valid read: `prdata` ← `mem[addr]`; `pslverr`←0.
- **RESP**
  - Lasts exactly one cycle.
  - On the next edge, clear `pready`, `pslverr` and `prdata` to 0 and go to IDLE.
- Address, data and direction are taken from the setup-phase latch, not from live inputs. Changes to `paddr`/`pwdata` during the access phase are ignored.
- Addresses are compared as 8-bit unsigned values; there is no wrap-around or aliasing.

## Timing
- **Reset values:** `pready`=0, `pslverr`=0, `prdata`=0, state=IDLE, `cnt`=0, and all `mem` entries = 0.
- **Reset during WAIT or RESP:**
  - The transfer is dropped immediately (asynchronous reset).
  - A write is only committed if its RESP-entry edge occurred before reset asserted.
- **Cycle numbering:** T0 is the setup cycle, T1 is the first `penable`=1 cycle, and W = WAIT_CYCLES.
  - `pready` is high during cycle T(W+2).
  - The access phase is W+2 cycles long; the full transfer is W+3 cycles including setup.
  - The minimum is one wait state, since `pready` is registered; W=0 gives `pready` in T2.
- **Write commit:** the write is visible to a read whose setup cycle is T(W+3) or later (back-to-back transfers).
- **Back-to-back transfers:** the requester may assert a new setup phase in the cycle immediately after RESP. IDLE accepts it in that cycle, so there are no dead cycles.
- **`psel` and `penable` together in IDLE:** `psel`=1 with `penable`=1 (no preceding setup) is a protocol violation. It is ignored and the block stays in IDLE.
- **Setup held multiple cycles:** if `psel`=1 and `penable`=0 for several cycles, WAIT holds and `cnt` is not decremented until `penable` rises.

## Test plan
- **Reset state:** assert `prst` mid-simulation → `pready`/`pslverr`/`prdata` = 0 asynchronously; a read of addr 0x05 returns 0x00.
- **Write then read, default W=2:**
  - Write 0xA5 to 0x03, then read 0x03.
  - Each transfer sees `pready` high in T4 only.
  - The read returns `prdata`=0xA5 with `pslverr`=0.
- **Out of range, DEPTH=16:**
  - Write 0x77 to 0x10 → `pready` with `pslverr`=1.
  - A following read of 0x10 → `pslverr`=1 and `prdata`=0x00.
  - A read of 0x00 is unchanged.
- **W=0 back-to-back:**
  - Write 0x11 to 0x0F, immediately followed by a read of 0x0F.
  - `pready` is high in T2 of each transfer; the read returns 0x11; there are no idle cycles between transfers.
- **Abort:**
  - Setup a write of 0x3C to 0x02, then drop `psel` in T1.
  - `pready` never asserts; a subsequent read of 0x02 returns its prior value 0x00.
- **Access-phase input changes:**
  - Change `paddr` to 0x09 and `pwdata` to 0xFF during the access phase of a write of 0x5A to 0x04.
  - 0x04 holds 0x5A and 0x09 is unchanged.
